// File: rtl/wave_mem_pkg.sv
// Shared types and constants for the wave memory responder: FSM encoding,
// default latencies and data/mask geometry.
package wave_mem_pkg;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        READ_WAIT  = 2'd1,
        WRITE_WAIT = 2'd2
    } state_t;

    localparam int DEFAULT_READ_LATENCY  = 2;
    localparam int DEFAULT_WRITE_LATENCY = 1;
    localparam int MASK_WIDTH            = 4;
    localparam int WORD_WIDTH            = 8 * MASK_WIDTH;
    localparam int LAT_WIDTH             = 4;

endpackage

// File: rtl/wave_ram_array.sv
// Single-port word array with synchronous read and per-byte write enables.
// Only the read-data register is reset; stored words survive reset.
module wave_ram_array
    import wave_mem_pkg::*;
#(
    parameter int WORDS  = 4096,
    parameter int ADDR_W = $clog2(WORDS)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  en,
    input  logic                  write,
    input  logic [MASK_WIDTH-1:0] byte_en,
    input  logic [ADDR_W-1:0]     addr,
    input  logic [WORD_WIDTH-1:0] wdata,
    output logic [WORD_WIDTH-1:0] rdata
);

    logic [WORD_WIDTH-1:0] mem [WORDS];

    // NOTE: the array has no reset branch on purpose; clearing it would turn
    // the RAM into thousands of resettable flops and break block-RAM inference.
    always_ff @(posedge clk) begin
        if (en && write) begin
            for (int i = 0; i < MASK_WIDTH; i++) begin
                if (byte_en[i]) begin
                    mem[addr][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rdata <= '0;
        end else if (en && !write) begin
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/wave_memory_responder.sv
// Core-facing memory responder: accepts one load or store at a time from IDLE,
// holds busy for a fixed latency, then completes the access in wave_ram_array.
module wave_memory_responder
    import wave_mem_pkg::*;
#(
    parameter int MEM_WORDS     = 4096,
    parameter int READ_LATENCY  = DEFAULT_READ_LATENCY,
    parameter int WRITE_LATENCY = DEFAULT_WRITE_LATENCY
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  load,
    input  logic                  store,
    input  logic [31:0]           memory_access_address,
    input  logic [WORD_WIDTH-1:0] memory_write_data,
    input  logic [MASK_WIDTH-1:0] memory_write_mask,
    output logic                  memory_read_busy,
    output logic [WORD_WIDTH-1:0] memory_read_data,
    output logic                  memory_write_busy,
    output logic                  access_error
);

    localparam int IDX_W = $clog2(MEM_WORDS);

    state_t                state;
    state_t                next_state;
    logic [LAT_WIDTH-1:0]  count;
    logic [IDX_W-1:0]      addr_q;
    logic [WORD_WIDTH-1:0] wdata_q;
    logic [MASK_WIDTH-1:0] mask_q;
    logic                  accept_read;
    logic                  accept_write;
    logic                  finish;
    logic                  ram_en;
    logic                  ram_write;
    logic                  unused_addr_bits;

    // Byte offset and bits above the word index are dropped, so addresses wrap.
    assign unused_addr_bits = ^{memory_access_address[31:IDX_W+2], memory_access_address[1:0]};

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (store) begin
                    next_state = WRITE_WAIT;
                end else if (load) begin
                    next_state = READ_WAIT;
                end
            end
            READ_WAIT, WRITE_WAIT: begin
                if (count <= LAT_WIDTH'(1)) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // NOTE: every comb output gets a default first so no path leaves a latch.
    always_comb begin
        accept_read  = 1'b0;
        accept_write = 1'b0;
        finish       = 1'b0;
        ram_write    = 1'b0;
        case (state)
            IDLE: begin
                accept_write = store;
                accept_read  = load && !store;
            end
            READ_WAIT: begin
                finish = (count <= LAT_WIDTH'(1));
            end
            WRITE_WAIT: begin
                finish    = (count <= LAT_WIDTH'(1));
                ram_write = 1'b1;
            end
            default: ;
        endcase
        // Reset on the completing edge aborts the access, so nothing commits.
        ram_en = finish && !reset;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count             <= '0;
            memory_read_busy  <= 1'b0;
            memory_write_busy <= 1'b0;
            access_error      <= 1'b0;
        end else if (accept_write) begin
            count             <= LAT_WIDTH'(WRITE_LATENCY);
            memory_write_busy <= 1'b1;
            if (load) begin
                access_error <= 1'b1;
            end
        end else if (accept_read) begin
            count            <= LAT_WIDTH'(READ_LATENCY);
            memory_read_busy <= 1'b1;
        end else if (finish) begin
            count             <= '0;
            memory_read_busy  <= 1'b0;
            memory_write_busy <= 1'b0;
        end else if (state != IDLE) begin
            count <= count - LAT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && (accept_write || accept_read)) begin
            addr_q  <= memory_access_address[IDX_W+1:2];
            wdata_q <= memory_write_data;
            mask_q  <= memory_write_mask;
        end
    end

    wave_ram_array #(
        .WORDS (MEM_WORDS)
    ) u_ram (
        .clk     (clk),
        .reset   (reset),
        .en      (ram_en),
        .write   (ram_write),
        .byte_en (mask_q),
        .addr    (addr_q),
        .wdata   (wdata_q),
        .rdata   (memory_read_data)
    );

endmodule

// File: tb/tb_wave_memory_responder.sv
// Self-checking bench: two responder instances (default and slow/small
// configuration) checked against a transaction-level model of the word array.
module tb_wave_memory_responder;

    logic        clk = 1'b0;
    logic        reset_a, reset_b;
    logic        load, store;
    logic [31:0] address, wdata;
    logic [3:0]  wmask;
    logic        rbusy_a, wbusy_a, err_a, rbusy_b, wbusy_b, err_b;
    logic [31:0] rdata_a, rdata_b;

    int checks = 0;
    int errors = 0;

    // Currently observed instance and its configuration.
    int sel = 0;
    int cur_words = 4096;
    int cur_rlat  = 2;
    int cur_wlat  = 1;

    logic        rbusy, wbusy, err;
    logic [31:0] rdata;
    assign rbusy = (sel != 0) ? rbusy_b : rbusy_a;
    assign wbusy = (sel != 0) ? wbusy_b : wbusy_a;
    assign err   = (sel != 0) ? err_b   : err_a;
    assign rdata = (sel != 0) ? rdata_b : rdata_a;

    // Reference model: word array, last completed read, sticky error.
    logic [31:0] m_mem [int];
    logic [31:0] m_rdata;
    logic        m_err;

    always #5 clk = ~clk;

    wave_memory_responder u_dut_a (
        .clk                   (clk),
        .reset                 (reset_a),
        .load                  (load),
        .store                 (store),
        .memory_access_address (address),
        .memory_write_data     (wdata),
        .memory_write_mask     (wmask),
        .memory_read_busy      (rbusy_a),
        .memory_read_data      (rdata_a),
        .memory_write_busy     (wbusy_a),
        .access_error          (err_a)
    );

    wave_memory_responder #(
        .MEM_WORDS     (64),
        .READ_LATENCY  (4),
        .WRITE_LATENCY (3)
    ) u_dut_b (
        .clk                   (clk),
        .reset                 (reset_b),
        .load                  (load),
        .store                 (store),
        .memory_access_address (address),
        .memory_write_data     (wdata),
        .memory_write_mask     (wmask),
        .memory_read_busy      (rbusy_b),
        .memory_read_data      (rdata_b),
        .memory_write_busy     (wbusy_b),
        .access_error          (err_b)
    );

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Starts and ends at a negedge; the next operation may be driven at once,
    // which exercises back-to-back acceptance.
    task automatic do_op(input bit st, input bit ld, input logic [31:0] addr,
                         input logic [31:0] data, input logic [3:0] mask, input bit scramble);
        int          lat;
        int          idx;
        logic [31:0] bm;
        idx   = int'((addr >> 2) % cur_words);
        load  = ld;
        store = st;
        address = addr;
        wdata = data;
        wmask = mask;
        @(posedge clk);
        lat = st ? cur_wlat : cur_rlat;
        if (st && ld) m_err = 1'b1;
        for (int k = 0; k < lat; k++) begin
            @(negedge clk);
            check(st ? "write_busy_high" : "read_busy_high", st ? wbusy : rbusy, 1);
            check("other_busy_low", st ? rbusy : wbusy, 0);
            if (scramble) begin
                load    = 1'b1;
                store   = 1'($urandom_range(0, 1));
                address = $urandom;
                wdata   = $urandom;
                wmask   = 4'($urandom);
            end else begin
                load  = 1'b0;
                store = 1'b0;
            end
        end
        if (st) begin
            bm = {{8{mask[3]}}, {8{mask[2]}}, {8{mask[1]}}, {8{mask[0]}}};
            m_mem[idx] = (m_mem.exists(idx) ? (m_mem[idx] & ~bm) : 32'h0) | (data & bm);
        end else begin
            m_rdata = m_mem[idx];
        end
        @(negedge clk);
        load  = 1'b0;
        store = 1'b0;
        check("read_busy_done", rbusy, 0);
        check("write_busy_done", wbusy, 0);
        check(st ? "read_data_held" : "read_data", rdata, m_rdata);
        check("access_error", err, m_err);
    endtask

    task automatic model_reset();
        m_mem.delete();
        m_rdata = 32'h0;
        m_err   = 1'b0;
    endtask

    initial begin
        int          pool [6];
        logic [31:0] a;

        // Phase 1: default instance; requests held during reset must be ignored.
        reset_a = 1'b1;
        reset_b = 1'b1;
        load    = 1'b1;
        store   = 1'b1;
        address = 32'h10;
        wdata   = 32'h1;
        wmask   = 4'hf;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_a = 1'b0;
        load    = 1'b0;
        store   = 1'b0;
        check("reset_read_busy", rbusy, 0);
        check("reset_write_busy", wbusy, 0);
        check("reset_read_data", rdata, 32'h0);
        check("reset_error", err, 0);

        do_op(1, 0, 32'h10, 32'hDEADBEEF, 4'b1111, 0);
        do_op(0, 1, 32'h10, 32'h0, 4'h0, 0);
        check("full_word_read", rdata, 32'hDEADBEEF);

        do_op(1, 0, 32'h10, 32'h00AA0000, 4'b0100, 0);
        do_op(0, 1, 32'h10, 32'h0, 4'h0, 0);
        check("byte_merge_read", rdata, 32'hDEAABEEF);

        do_op(1, 0, 32'h13, 32'h11223344, 4'b0000, 0);
        do_op(0, 1, 32'h10, 32'h0, 4'h0, 0);
        check("zero_mask_read", rdata, 32'hDEAABEEF);

        do_op(1, 0, 32'h18, 32'hA5A55A5A, 4'b1111, 1);
        do_op(0, 1, 32'h18, 32'h0, 4'h0, 1);
        check("captured_data_read", rdata, 32'hA5A55A5A);
        check("no_error_during_busy", err, 0);

        do_op(1, 0, 32'h4004, 32'hC0FFEE01, 4'b1111, 0);
        do_op(0, 1, 32'h0004, 32'h0, 4'h0, 0);
        check("wrap_read", rdata, 32'hC0FFEE01);

        do_op(1, 1, 32'h20, 32'h12345678, 4'b1111, 0);
        check("collision_error", err, 1);
        do_op(0, 1, 32'h20, 32'h0, 4'h0, 0);
        check("collision_read", rdata, 32'h12345678);
        check("error_sticky", err, 1);

        for (int j = 0; j < 6; j++) begin
            pool[j] = 100 + 37 * j;
            do_op(1, 0, 32'(pool[j]) << 2, $urandom, 4'hf, 0);
        end
        for (int n = 0; n < 40; n++) begin
            a = ($urandom << 14) | (32'(pool[$urandom_range(0, 5)]) << 2) | 32'($urandom_range(0, 3));
            if ($urandom_range(0, 1) == 1) begin
                do_op(1, ($urandom_range(0, 3) == 0), a, $urandom, 4'($urandom), 1'($urandom_range(0, 1)));
            end else begin
                do_op(0, 1, a, $urandom, 4'($urandom), 1'($urandom_range(0, 1)));
            end
        end

        // Phase 2: small, slow instance (64 words, read 4, write 3).
        @(negedge clk);
        reset_a   = 1'b1;
        sel       = 1;
        cur_words = 64;
        cur_rlat  = 4;
        cur_wlat  = 3;
        model_reset();
        @(negedge clk);
        reset_b = 1'b0;
        check("b_reset_read_data", rdata, 32'h0);
        check("b_reset_busy", rbusy | wbusy, 0);

        do_op(1, 0, 32'h30, 32'h0, 4'hf, 0);
        // Reset in the first busy cycle aborts the write; a request is held
        // during the reset cycle and must be dropped.
        store   = 1'b1;
        address = 32'h30;
        wdata   = 32'hCAFEF00D;
        wmask   = 4'hf;
        @(posedge clk);
        @(negedge clk);
        check("abort_write_busy_high", wbusy, 1);
        reset_b = 1'b1;
        store   = 1'b0;
        load    = 1'b1;
        @(negedge clk);
        reset_b = 1'b0;
        load    = 1'b0;
        check("abort_write_busy", wbusy, 0);
        check("abort_read_busy", rbusy, 0);
        check("abort_error", err, 0);
        @(negedge clk);
        check("reset_cycle_request_dropped", rbusy, 0);
        do_op(0, 1, 32'h30, 32'h0, 4'h0, 0);
        check("abort_no_commit", rdata, 32'h0);

        do_op(1, 0, 32'h108, 32'h0BADCAFE, 4'hf, 0);
        do_op(0, 1, 32'h008, 32'h0, 4'h0, 0);
        check("b_wrap_read", rdata, 32'h0BADCAFE);
        do_op(1, 0, 32'h30, 32'h77665544, 4'b1010, 1);
        do_op(0, 1, 32'h130, 32'h0, 4'h0, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/wave_memory_responder.md
WAVE_MEMORY_RESPONDER -- requirements
Module: wave_memory_responder

Interface
REQ-001 Parameter MEM_WORDS, default 4096: depth of the internal 32-bit word array; SHALL be a power of two.
REQ-002 Parameter READ_LATENCY, default 2: busy cycles per read; legal range 1..15.
REQ-003 Parameter WRITE_LATENCY, default 1: busy cycles per write; legal range 1..15.
REQ-004 clk  input  1  the single clock; all state SHALL update on its rising edge.
REQ-005 reset  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
REQ-006 load  input  1  read request from the core.
REQ-007 store  input  1  write request from the core.
REQ-008 memory_access_address  input  32  byte address; bits [1:0] ignored; word index = address[31:2] modulo MEM_WORDS.
REQ-009 memory_write_data  input  32  write data, already lane-aligned by the core.
REQ-010 memory_write_mask  input  4  byte enables; bit n enables byte lane [8n+7:8n].
REQ-011 memory_read_busy  output  1  high while a read is in progress.
REQ-012 memory_read_data  output  32  full aligned word from the last completed read.
REQ-013 memory_write_busy  output  1  high while a write is in progress.
REQ-014 access_error  output  1  sticky flag for protocol violations.

Function
REQ-015 FSM states: IDLE, READ_WAIT, WRITE_WAIT; encoding is defined in the shared package.
REQ-016 In IDLE, with store=1, the block SHALL capture address, data and mask on that edge, enter WRITE_WAIT, and load the latency counter with WRITE_LATENCY.
REQ-017 In IDLE, with load=1 and store=0, the block SHALL capture the address on that edge, enter READ_WAIT, and load the latency counter with READ_LATENCY.
REQ-018 If load=1 and store=1 in IDLE, the store SHALL win, the load SHALL be dropped, and access_error SHALL set.
REQ-019 Latency: memory_read_busy/memory_write_busy SHALL be registered, SHALL go high in the cycle after acceptance, and SHALL stay high for exactly the configured number of cycles.
REQ-020 At the edge on which busy falls, a read SHALL register the array word into memory_read_data, and a write SHALL commit masked bytes to the array; the FSM SHALL then return to IDLE.
REQ-021 memory_read_data SHALL hold its value until the next read completes; writes SHALL NOT alter it.
REQ-022 Captured operands SHALL be used; core input changes during busy SHALL be ignored.
REQ-023 Requests asserted while not in IDLE SHALL be ignored and SHALL NOT set access_error.
REQ-024 The block SHALL accept back-to-back requests: a request present in the first IDLE cycle after busy falls SHALL be accepted.
REQ-025 Mask 4'b0000 SHALL complete a normal write handshake with no array change.
REQ-026 An address at or beyond MEM_WORDS*4 SHALL wrap by word index without error.
REQ-027 A read after a write to the same word SHALL return the newly written bytes, merged with the unmasked old bytes.

Reset
REQ-028 On reset the FSM SHALL go to IDLE, the counter to 0, both busy outputs to 0, memory_read_data to 32'h0 and access_error to 0.
REQ-029 Reset during READ_WAIT or WRITE_WAIT SHALL abort the operation; a pending write SHALL NOT commit.
REQ-030 Array contents SHALL NOT be cleared by reset.
REQ-031 Requests present in the reset cycle SHALL be ignored.

Structure
REQ-032 Package wave_mem_pkg SHALL hold the FSM state typedef, the default latency constants and the mask width constant.
REQ-033 The word array SHALL be a sub-module wave_ram_array: single-port, synchronous read, per-byte write enable.
REQ-034 The FSM, counter and operand capture registers SHALL reside in wave_memory_responder.

Verification
REQ-035 Store addr 0x10, data 0xDEADBEEF, mask 4'b1111 with WRITE_LATENCY=1, then load 0x10 -> write_busy high 1 cycle; read_busy high 2 cycles; read_data=0xDEADBEEF when busy falls.
REQ-036 Store addr 0x10, data 0x00AA0000, mask 4'b0100 over 0xDEADBEEF, then load -> 0xDEAABEEF.
REQ-037 Assert load and store together at addr 0x20, data 0x12345678 -> write occurs, access_error=1 and stays 1, a subsequent load returns 0x12345678.
REQ-038 Assert reset in the 1st cycle of a write (WRITE_LATENCY=3) to 0x30 that held 0x0 -> busy=0 next cycle; a load of 0x30 returns 0x0.
REQ-039 With MEM_WORDS=4096, store to 0x4004, then load 0x0004 -> returns the stored word.
REQ-040 Change memory_write_data mid-write, and assert load during write_busy -> committed data is the captured value; no read starts; access_error remains 0.
